// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the memory burst master.
package mem_pkg;

  localparam int unsigned MEM_WIDTH      = 16;
  localparam int unsigned MEM_DEPTH      = 16;
  localparam int unsigned MEM_ADDR_WIDTH = 4;

  // Burst master control states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_MEM  = 3'd2,
    RD_MEM  = 3'd3,
    RD_OUT  = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mem_burst_cnt.sv
// Burst address/remaining-count tracker: load at command, step per completed transfer.
module mem_burst_cnt
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = MEM_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  dec_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   remaining_o
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  // Load takes priority; a decrement advances the address with wrap at DEPTH-1
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_o      <= '0;
      remaining_o <= '0;
    end else if (load_i) begin
      addr_o      <= addr_i;
      remaining_o <= len_i;
    end else if (dec_i) begin
      addr_o      <= (addr_o == ADDR_LAST) ? '0 : addr_o + ADDR_WIDTH'(1);
      remaining_o <= remaining_o - LW'(1);
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst master: turns one read/write command into a sequence of single memory accesses.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = MEM_WIDTH,
  parameter int unsigned DEPTH      = MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  done_o
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

  state_e state_q;
  state_e state_d;

  logic            cmd_fire;
  logic            wdata_fire;
  logic            mem_fire;
  logic            rd_fire;
  logic [LW-1:0]   len_sat;
  logic            cnt_load;
  logic            cnt_dec;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic [LW-1:0]   cnt_remaining;

  // Handshakes use the registered ready/valid outputs, which mirror the current state
  assign cmd_fire   = cmd_valid_i && cmd_ready_o;
  assign wdata_fire = wdata_valid_i && wdata_ready_o;
  assign mem_fire   = mem_valid_o && mem_ready_i;
  assign rd_fire    = rd_valid_o && rd_ready_i;
  assign len_sat    = (cmd_len_i > DEPTH_LEN) ? DEPTH_LEN : cmd_len_i;

  // The counter's address register drives the memory address directly
  assign mem_addr_o = cnt_addr;

  mem_burst_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (cnt_load),
    .addr_i      (cmd_addr_i),
    .len_i       (len_sat),
    .dec_i       (cnt_dec),
    .addr_o      (cnt_addr),
    .remaining_o (cnt_remaining)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          cnt_load = 1'b1;
          if (len_sat == '0) begin
            state_d = DONE;
          end else if (cmd_wr_i) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_MEM;
          end
        end
      end
      WR_DATA: begin
        if (wdata_fire) begin
          state_d = WR_MEM;
        end
      end
      WR_MEM: begin
        if (mem_fire) begin
          cnt_dec = 1'b1;
          state_d = (cnt_remaining == LW'(1)) ? DONE : WR_DATA;
        end
      end
      RD_MEM: begin
        if (mem_fire) begin
          cnt_dec = 1'b1;
          state_d = RD_OUT;
        end
      end
      RD_OUT: begin
        // Remaining count was already stepped when the read completed
        if (rd_fire) begin
          state_d = (cnt_remaining == '0) ? DONE : RD_MEM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: strobes decoded from the next state, data captured on handshakes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_ready_o   <= 1'b0;
      wdata_ready_o <= 1'b0;
      mem_valid_o   <= 1'b0;
      rd_valid_o    <= 1'b0;
      done_o        <= 1'b0;
      mem_wr_rd_o   <= 1'b0;
      mem_wdata_o   <= '0;
      rd_data_o     <= '0;
    end else begin
      cmd_ready_o   <= (state_d == IDLE);
      wdata_ready_o <= (state_d == WR_DATA);
      mem_valid_o   <= (state_d == WR_MEM) || (state_d == RD_MEM);
      rd_valid_o    <= (state_d == RD_OUT);
      done_o        <= (state_d == DONE);
      if (cmd_fire) begin
        mem_wr_rd_o <= cmd_wr_i;
      end
      if (wdata_fire) begin
        mem_wdata_o <= wdata_i;
      end
      if (mem_fire && !mem_wr_rd_o) begin
        rd_data_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: memory slave model, reference model, directed + random bursts.
module tb_mem_burst_master;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [W-1:0]  wdata = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [W-1:0]  rd_data;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic          mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          done;

  int total = 0;
  int bad   = 0;

  // Stimulus modes: 0 = tied ready, 1 = fixed 3-cycle stall / toggle, 2 = random
  int stall_mode = 0;
  int rd_mode    = 0;
  int wd_gap     = 0;
  int wait_cnt   = 0;

  logic [W-1:0] tb_mem  [D];
  logic [W-1:0] ref_mem [D];
  acc_t         acc_q [$];
  logic [W-1:0] rd_q  [$];
  int           done_cnt  = 0;
  int           valid_cnt = 0;

  logic          p_ms = 1'b0;
  logic          p_rs = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [W-1:0]  p_wdata = '0;
  logic          p_wr = 1'b0;
  logic [W-1:0]  p_rd = '0;

  mem_burst_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_wr_i      (cmd_wr),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready),
    .wdata_i       (wdata),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .rd_data_o     (rd_data),
    .mem_valid_o   (mem_valid),
    .mem_ready_i   (mem_ready),
    .mem_wr_rd_o   (mem_wr_rd),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Read data is only meaningful in the completing cycle; garbage otherwise
  assign mem_rdata = mem_ready ? tb_mem[mem_addr] : 16'hDEAD;

  function automatic logic [W-1:0] init_word(input int i);
    return W'(i * 32'h1111) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory and downstream responders, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0: mem_ready = 1'b1;
      1: begin
        if (mem_ready) begin
          mem_ready = 1'b0;
          wait_cnt  = 0;
        end else if (mem_valid) begin
          wait_cnt++;
          if (wait_cnt > 3) mem_ready = 1'b1;
        end else begin
          wait_cnt = 0;
        end
      end
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    case (rd_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = ~rd_ready;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Memory slave storage and transaction logger
  initial begin
    for (int i = 0; i < D; i++) tb_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mem_valid) valid_cnt++;
      if (mem_valid && mem_ready) begin
        acc_q.push_back({mem_wr_rd, mem_addr, mem_wdata});
        if (mem_wr_rd) tb_mem[mem_addr] = mem_wdata;
      end
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (done) done_cnt++;
    end
  end

  // Advance to the next falling edge and check stall stability
  task automatic tick();
    @(negedge clk);
    if (p_ms && mem_valid) begin
      check("mem_addr_stable", 32'(mem_addr), 32'(p_addr));
      check("mem_wdata_stable", 32'(mem_wdata), 32'(p_wdata));
      check("mem_wr_stable", 32'(mem_wr_rd), 32'(p_wr));
    end
    if (p_rs && rd_valid) check("rd_data_stable", 32'(rd_data), 32'(p_rd));
    p_ms    = mem_valid && !mem_ready;
    p_rs    = rd_valid && !rd_ready;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
    p_wr    = mem_wr_rd;
    p_rd    = rd_data;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW:0] len);
    bit fired = 0;
    int cyc = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!fired && cyc < 50) begin
      tick();
      if (cmd_ready) fired = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("cmd_accept", 32'(fired), 32'd1);
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = (AW + 1)'($urandom);
  endtask

  // One full burst checked against the reference model; starts and ends just after a rising edge
  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input logic [AW:0] len,
                           input bit seq);
    int n = (int'(len) > D) ? D : int'(len);
    logic [W-1:0] wq [$];
    acc_t exp_acc [$];
    logic [W-1:0] exp_rd [$];
    int base_a = acc_q.size();
    int base_r = rd_q.size();
    int base_d = done_cnt;
    int base_v = valid_cnt;
    int idx = 0;
    int cyc = 0;
    bit done_seen = 0;
    int got;

    for (int k = 0; k < n; k++) begin
      int a = (int'(addr) + k) % D;
      if (wr) begin
        logic [W-1:0] d = seq ? W'(k) : W'($urandom);
        wq.push_back(d);
        exp_acc.push_back({1'b1, AW'(a), d});
        ref_mem[a] = d;
      end else begin
        exp_acc.push_back({1'b0, AW'(a), W'(0)});
        exp_rd.push_back(ref_mem[a]);
      end
    end

    send_cmd(wr, addr, len);
    while (!done_seen && cyc < 1000) begin
      wdata_valid = (idx < n) && (wd_gap == 0 || $urandom_range(0, 1) == 1);
      wdata       = (idx < n) ? wq[idx] : W'($urandom);
      tick();
      if (wdata_valid && wdata_ready) idx++;
      if (done) begin
        done_seen = 1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    wdata_valid = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    if (len == 0) begin
      check("len0_done_latency", 32'(cyc), 32'd0);
      check("len0_no_mem_valid", 32'(valid_cnt - base_v), 32'd0);
    end
    tick();
    check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    tick();
    check("done_pulse_count", 32'(done_cnt - base_d), 32'd1);

    got = acc_q.size() - base_a;
    check("access_count", 32'(got), 32'(n));
    for (int i = 0; i < n && i < got; i++) begin
      acc_t o = acc_q[base_a + i];
      check("access_wr", 32'(o.wr), 32'(exp_acc[i].wr));
      check("access_addr", 32'(o.addr), 32'(exp_acc[i].addr));
      if (wr) check("access_wdata", 32'(o.data), 32'(exp_acc[i].data));
    end
    if (!wr) begin
      got = rd_q.size() - base_r;
      check("read_count", 32'(got), 32'(n));
      for (int i = 0; i < n && i < got; i++)
        check("read_data", 32'(rd_q[base_r + i]), 32'(exp_rd[i]));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] rd_wq [8];
    int base_a;
    int base_d;
    int wr_seen;
    int idx;
    int cyc;

    for (int i = 0; i < D; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (2) tick();
    check("rst_ctrl", 32'({cmd_ready, wdata_ready, rd_valid, mem_valid, mem_wr_rd, done}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("cmd_ready_before_first_clk", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    tick();
    check("cmd_ready_after_first_clk", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Sequential write then read of the full memory
    run_burst(1'b1, 4'd0, 5'd16, 1'b1);
    run_burst(1'b0, 4'd0, 5'd16, 1'b0);
    // Address wrap
    run_burst(1'b1, 4'd14, 5'd4, 1'b0);
    run_burst(1'b0, 4'd14, 5'd4, 1'b0);
    // Stalled memory and toggling downstream ready
    stall_mode = 1;
    rd_mode    = 1;
    wd_gap     = 1;
    run_burst(1'b1, 4'd5, 5'd6, 1'b0);
    run_burst(1'b0, 4'd5, 5'd6, 1'b0);
    // Zero length and saturated length
    stall_mode = 0;
    rd_mode    = 0;
    wd_gap     = 0;
    run_burst(1'b1, 4'd7, 5'd0, 1'b0);
    run_burst(1'b0, 4'd9, 5'd0, 1'b0);
    run_burst(1'b1, 4'd3, 5'd20, 1'b0);
    run_burst(1'b0, 4'd3, 5'd20, 1'b0);

    // Reset in the middle of an 8-word write after 3 writes complete
    for (int k = 0; k < 8; k++) rd_wq[k] = W'($urandom) | 16'h0100;
    base_a  = acc_q.size();
    base_d  = done_cnt;
    wr_seen = 0;
    idx     = 0;
    cyc     = 0;
    send_cmd(1'b1, 4'd2, 5'd8);
    while (wr_seen < 3 && cyc < 200) begin
      wdata_valid = 1'b1;
      wdata       = rd_wq[idx];
      tick();
      if (wdata_valid && wdata_ready) idx++;
      if (mem_valid && mem_ready) wr_seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_writes_reached", 32'(wr_seen), 32'd3);
    rst = 1'b0;
    #1;
    check("abort_rst_ctrl", 32'({cmd_ready, wdata_ready, rd_valid, mem_valid, mem_wr_rd, done}), 32'd0);
    check("abort_rst_addr", 32'(mem_addr), 32'd0);
    check("abort_rst_wdata", 32'(mem_wdata), 32'd0);
    check("abort_rst_rdata", 32'(rd_data), 32'd0);
    wdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("abort_cmd_ready_held", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    tick();
    check("abort_cmd_ready_released", 32'(cmd_ready), 32'd1);
    repeat (8) tick();
    check("abort_no_done", 32'(done_cnt - base_d), 32'd0);
    check("abort_access_count", 32'(acc_q.size() - base_a), 32'd3);
    for (int k = 0; k < 3 && base_a + k < acc_q.size(); k++) begin
      check("abort_addr", 32'(acc_q[base_a + k].addr), 32'(2 + k));
      check("abort_wdata", 32'(acc_q[base_a + k].data), 32'(rd_wq[k]));
      ref_mem[2 + k] = rd_wq[k];
    end
    @(posedge clk);
    #1;

    // Randomized bursts and handshake timing
    for (int b = 0; b < 14; b++) begin
      stall_mode = $urandom_range(0, 2);
      rd_mode    = $urandom_range(0, 2);
      wd_gap     = $urandom_range(0, 1);
      run_burst(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
                (AW + 1)'($urandom_range(0, 20)), 1'b0);
    end
    // Final full read to confirm memory contents match the model
    stall_mode = 2;
    rd_mode    = 2;
    run_burst(1'b0, 4'd0, 5'd16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, memory data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of memory locations.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, memory address width (DEPTH = 2**ADDR_WIDTH).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid_i  input  1  burst command offered.
REQ-007 SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 SHALL have port cmd_wr_i  input  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port cmd_addr_i  input  ADDR_WIDTH  burst start address.
REQ-010 SHALL have port cmd_len_i  input  ADDR_WIDTH+1  number of locations in burst.
REQ-011 SHALL have port wdata_valid_i  input  1  write-data word offered.
REQ-012 SHALL have port wdata_ready_o  output  1  write-data word accepted.
REQ-013 SHALL have port wdata_i  input  WIDTH  write-data word.
REQ-014 SHALL have port rd_valid_o  output  1  read-data word offered downstream.
REQ-015 SHALL have port rd_ready_i  input  1  downstream accepts read word.
REQ-016 SHALL have port rd_data_o  output  WIDTH  read-data word.
REQ-017 SHALL have port mem_valid_o  output  1  memory access request, to memory valid_i.
REQ-018 SHALL have port mem_ready_i  input  1  memory completes access, from memory ready_o.
REQ-019 SHALL have port mem_wr_rd_o  output  1  1 = write, 0 = read, to memory wr_rd_i.
REQ-020 SHALL have port mem_addr_o  output  ADDR_WIDTH  access address, to memory addr_i.
REQ-021 SHALL have port mem_wdata_o  output  WIDTH  write data, to memory wdata_i.
REQ-022 SHALL have port mem_rdata_i  input  WIDTH  read data, from memory rdata_o.
REQ-023 SHALL have port done_o  output  1  one-cycle pulse at burst end.

Function
REQ-024 SHALL implement FSM states IDLE, WR_DATA, WR_MEM, RD_MEM, RD_OUT, DONE; cmd_ready_o high only in IDLE.
REQ-025 SHALL, on cmd handshake in IDLE, latch cmd_wr_i, cmd_addr_i, cmd_len_i; go WR_DATA (write) or RD_MEM (read).
REQ-026 SHALL saturate cmd_len_i above DEPTH to DEPTH; cmd_len_i = 0 goes directly to DONE with no memory access.
REQ-027 SHALL assert wdata_ready_o only in WR_DATA; on wdata handshake register the word into mem_wdata_o and go WR_MEM.
REQ-028 SHALL assert mem_valid_o only in WR_MEM and RD_MEM; mem_addr_o, mem_wr_rd_o, mem_wdata_o held stable until mem_valid_o && mem_ready_i.
REQ-029 SHALL count a memory transfer complete only in a cycle with mem_valid_o && mem_ready_i; mem_rdata_i sampled in that same cycle.
REQ-030 SHALL, after a write transfer, go WR_DATA if words remain, else DONE.
REQ-031 SHALL, after a read transfer, capture mem_rdata_i into rd_data_o and go RD_OUT; rd_valid_o high only in RD_OUT.
REQ-032 SHALL hold rd_data_o stable in RD_OUT until rd_ready_i; then go RD_MEM if words remain, else DONE.
REQ-033 SHALL increment address by 1 per completed transfer, wrapping modulo DEPTH (e.g. DEPTH-1 -> 0).
REQ-034 SHALL assert done_o for exactly one cycle in DONE, then return to IDLE.
REQ-035 SHALL ignore cmd_valid_i outside IDLE; at most one memory access outstanding at any time.

Reset
REQ-036 SHALL, while rst_i low, force IDLE and drive cmd_ready_o 0, all other outputs 0 (cmd_ready_o 1 from first clock after release).
REQ-037 SHALL abandon any burst on reset mid-operation with no further memory access or done_o pulse for it.

Structure
REQ-038 SHALL take WIDTH/DEPTH/ADDR_WIDTH defaults and FSM state encoding from shared package mem_pkg.
REQ-039 SHALL use one sub-module mem_burst_cnt holding next address and remaining-count, with load and decrement/wrap controls.

Verification
REQ-040 Write burst addr 0, len 16, data 0x0000..0x000F, mem_ready_i tied 1 -> 16 writes to addresses 0..15 in order, one done_o pulse.
REQ-041 Read burst addr 0, len 16 after REQ-040 -> rd_data_o sequence 0x0000..0x000F, one done_o.
REQ-042 Write addr 14, len 4 -> accesses to 14, 15, 0, 1 (wrap).
REQ-043 mem_ready_i low 3 cycles per access, rd_ready_i toggling -> mem_addr_o/mem_wdata_o/rd_data_o stable while stalled, no lost/duplicated words.
REQ-044 len 0 -> no mem_valid_o, done_o 1 cycle after command; len 20 -> exactly 16 accesses.
REQ-045 rst_i low mid-burst after 3 of 8 writes -> all outputs 0 immediately, cmd_ready_o 1 after release, no done_o.
